// File: rtl/cdc_utils_pkg.sv
// Shared definitions for the cdc_utils blocks: transmitter FSM states and the
// default synchronizer depth.
package cdc_utils_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } cdc_tx_state_e;

endpackage

// File: rtl/cdc_pulse_tx_if.sv
// Signal bundle of the toggle-based pulse transmitter: source-side strobes and
// status, plus the outgoing toggle and the toggle returned from the far domain.
interface cdc_pulse_tx_if #(
    parameter int unsigned CNT_W = 4
);
    logic             i_pulse;
    logic             i_ovf_clr;
    logic             i_ack_tgl;
    logic             o_tgl;
    logic             o_busy;
    logic [CNT_W-1:0] o_pend;
    logic             o_ovf;
    logic             o_tmo;

    modport master (
        output i_pulse,
        output i_ovf_clr,
        output i_ack_tgl,
        input  o_tgl,
        input  o_busy,
        input  o_pend,
        input  o_ovf,
        input  o_tmo
    );

    modport slave (
        input  i_pulse,
        input  i_ovf_clr,
        input  i_ack_tgl,
        output o_tgl,
        output o_busy,
        output o_pend,
        output o_ovf,
        output o_tmo
    );

endinterface

// File: rtl/cdc_sync2.sv
// Multi-flop level synchronizer with synchronous active-high reset; depth
// defaults to the shared SYNC_STAGES constant.
module cdc_sync2
    import cdc_utils_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic c,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge c) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_pulse_tx.sv
// Source-domain transmitter for toggle-based pulse crossing with a saturating
// pending queue. Optional ack watchdog enabled by CDC_PULSE_TX_TIMEOUT_EN.
module cdc_pulse_tx
    import cdc_utils_pkg::*;
#(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TMO_W = 8
) (
    input logic           c,
    input logic           rst,
    cdc_pulse_tx_if.slave bus
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    cdc_tx_state_e    state_q, state_d;
    logic             tgl_q, tgl_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             ack_done;
    logic             tmo_fire;

    cdc_sync2 u_ack_sync (
        .c  (c),
        .rst(rst),
        .d  (bus.i_ack_tgl),
        .q  (ack_s)
    );

    // Far side has caught up once its returned toggle matches ours.
    assign ack_done = (state_q == ST_WAIT) && (ack_s == tgl_q);

`ifdef CDC_PULSE_TX_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_q;

    assign tmo_fire = (state_q == ST_WAIT) && !ack_done && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (state_q != ST_WAIT || ack_done || tmo_fire) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_q | tmo_fire;
        end
    end

    assign bus.o_tmo = tmo_q;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = (TMO_W == 0);
    assign tmo_fire     = 1'b0;
    assign bus.o_tmo    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tgl_d   = tgl_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q & ~bus.i_ovf_clr;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_pulse) begin
                    tgl_d   = ~tgl_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_done) begin
                    // A coincident new event takes the slot just freed.
                    if (bus.i_pulse || pend_q != '0) begin
                        tgl_d = ~tgl_q;
                        if (!bus.i_pulse) begin
                            pend_d = pend_q - CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.i_pulse) begin
                    if (pend_q == PEND_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Watchdog abort: drop the queue and realign with the far side.
        if (tmo_fire) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            tgl_d   = ack_s;
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgl_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgl_q   <= tgl_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_tgl  = tgl_q;
    assign bus.o_busy = (state_q == ST_WAIT);
    assign bus.o_pend = pend_q;
    assign bus.o_ovf  = ovf_q;

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Loopback bench for cdc_pulse_tx: 100 MHz source clock, 37 MHz far receiver
// model, vector table, directed corner cases and randomized bursts.
`timescale 1ns/1ps
module tb_cdc_pulse_tx;

    logic c    = 1'b0;
    logic fclk = 1'b0;
    logic rst  = 1'b1;

    always #5    c    = ~c;
    always #13.5 fclk = ~fclk;

    cdc_pulse_tx_if #(.CNT_W(4)) bus ();

    logic ack_loop = 1'b0;
    logic ack_man  = 1'b0;
    logic far_r1, far_r2, far_r3;
    int   far_cnt  = 0;

    // Far-domain receiver: 2-flop sync, edge detect; q (far_r2) returns as ack.
    always @(posedge fclk or posedge rst) begin
        if (rst) begin
            far_r1 <= 1'b0;
            far_r2 <= 1'b0;
            far_r3 <= 1'b0;
        end else begin
            far_r1 <= bus.o_tgl;
            far_r2 <= far_r1;
            far_r3 <= far_r2;
        end
    end

    always @(posedge fclk) begin
        if (!rst && (far_r2 != far_r3)) far_cnt <= far_cnt + 1;
    end

    assign bus.i_ack_tgl = ack_loop ? far_r2 : ack_man;

    cdc_pulse_tx #(.CNT_W(4), .TMO_W(4)) dut (
        .c  (c),
        .rst(rst),
        .bus(bus)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_in = 0;
    int   flips = 0;
    logic tgl_prev = 1'b0;

    typedef struct packed {
        logic       p;
        logic       clr;
        logic       a;
        logic       tgl;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic p, logic clr, logic a, logic t, logic b, logic [3:0] pend);
        vec_t v;
        v.p = p; v.clr = clr; v.a = a; v.tgl = t; v.busy = b; v.pend = pend; v.ovf = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Advance one source clock; bookkeep accepted strobes and observed toggle flips.
    task automatic step();
        if (bus.i_pulse && !rst) n_in++;
        @(posedge c);
        #1;
        if (bus.o_tgl !== tgl_prev) flips++;
        tgl_prev = bus.o_tgl;
    endtask

    task automatic do_reset();
        bus.i_pulse   = 1'b0;
        bus.i_ovf_clr = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_in = 0;
        flips = 0;
        tgl_prev = bus.o_tgl;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (bus.o_busy && k < max) begin
            step();
            k++;
        end
        check({name, "_idle"}, {31'd0, bus.o_busy}, 32'd0);
        repeat (10) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int f0;
        vecs[0]  = mk(1, 0, 0, 1, 1, 0);  vecs[1]  = mk(1, 0, 0, 1, 1, 1);
        vecs[2]  = mk(1, 0, 1, 1, 1, 2);  vecs[3]  = mk(0, 0, 1, 1, 1, 2);
        vecs[4]  = mk(0, 0, 1, 0, 1, 1);  vecs[5]  = mk(0, 0, 1, 0, 1, 1);
        vecs[6]  = mk(1, 0, 0, 0, 1, 2);  vecs[7]  = mk(0, 0, 0, 0, 1, 2);
        vecs[8]  = mk(1, 0, 0, 1, 1, 2);  vecs[9]  = mk(0, 0, 1, 1, 1, 2);
        vecs[10] = mk(0, 0, 1, 1, 1, 2);  vecs[11] = mk(0, 0, 1, 0, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 1, 1);  vecs[13] = mk(0, 0, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 1, 0);  vecs[15] = mk(0, 0, 1, 1, 1, 0);
        vecs[16] = mk(0, 0, 1, 1, 1, 0);  vecs[17] = mk(0, 0, 1, 1, 0, 0);
        vecs[18] = mk(1, 0, 1, 0, 1, 0);  vecs[19] = mk(0, 0, 1, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 1, 0);  vecs[21] = mk(0, 0, 0, 0, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0);  vecs[23] = mk(0, 1, 0, 0, 0, 0);

        do_reset();
        check("reset_state", {bus.o_tgl, bus.o_busy, bus.o_pend, bus.o_ovf, bus.o_tmo}, 32'd0);

        // Manual-ack vector table: ack reaches the FSM two cycles after it is driven.
        for (int i = 0; i < 24; i++) begin
            bus.i_pulse   = vecs[i].p;
            bus.i_ovf_clr = vecs[i].clr;
            ack_man       = vecs[i].a;
            step();
            check($sformatf("vec%0d", i), {bus.o_tgl, bus.o_busy, bus.o_pend, bus.o_ovf},
                  {vecs[i].tgl, vecs[i].busy, vecs[i].pend, vecs[i].ovf});
        end
        bus.i_pulse = 1'b0;
        bus.i_ovf_clr = 1'b0;
        ack_man = 1'b0;

        // Single event through the loopback.
        do_reset();
        ack_loop = 1'b1;
        base = far_cnt;
        bus.i_pulse = 1'b1;
        step();
        bus.i_pulse = 1'b0;
        check("single_tgl", {31'd0, bus.o_tgl}, 32'd1);
        check("single_busy", {31'd0, bus.o_busy}, 32'd1);
        wait_idle("single", 60);
        check("single_far", far_cnt - base, 1);

        // Ten-cycle burst: every accepted event is either flipped out or queued.
        base = far_cnt;
        f0 = flips;
        bus.i_pulse = 1'b1;
        repeat (10) step();
        bus.i_pulse = 1'b0;
        check("burst_queue", (flips - f0) + int'(bus.o_pend), 10);
        check("burst_ovf", {31'd0, bus.o_ovf}, 32'd0);
        wait_idle("burst", 300);
        check("burst_far", far_cnt - base, 10);

`ifndef CDC_PULSE_TX_TIMEOUT_EN
        // Saturation with ack held back, then released into the loopback.
        do_reset();
        ack_loop = 1'b0;
        ack_man = 1'b0;
        base = far_cnt;
        bus.i_pulse = 1'b1;
        repeat (19) step();
        check("sat_pend", bus.o_pend, 32'd15);
        check("sat_ovf", {31'd0, bus.o_ovf}, 32'd1);
        bus.i_ovf_clr = 1'b1;
        step();
        check("sat_set_wins", {31'd0, bus.o_ovf}, 32'd1);
        bus.i_pulse = 1'b0;
        step();
        bus.i_ovf_clr = 1'b0;
        check("sat_clr", {31'd0, bus.o_ovf}, 32'd0);
        check("sat_pend_hold", bus.o_pend, 32'd15);
        ack_loop = 1'b1;
        wait_idle("sat", 600);
        check("sat_far", far_cnt - base, 16);
`endif

        // Coincidence of ack-complete and a new event with three queued.
        do_reset();
        ack_loop = 1'b0;
        ack_man = 1'b0;
        bus.i_pulse = 1'b1;
        repeat (4) step();
        bus.i_pulse = 1'b0;
        check("coin_pre", {bus.o_tgl, bus.o_pend}, {1'b1, 4'd3});
        ack_man = 1'b1;
        step();
        step();
        bus.i_pulse = 1'b1;
        step();
        bus.i_pulse = 1'b0;
        check("coin_post", {bus.o_tgl, bus.o_pend, bus.o_ovf}, {1'b0, 4'd3, 1'b0});

        // Reset in the middle of WAIT with five queued.
        bus.i_pulse = 1'b1;
        step();
        step();
        bus.i_pulse = 1'b0;
        check("mid_pend", {bus.o_busy, bus.o_pend}, {1'b1, 4'd5});
        rst = 1'b1;
        step();
        check("mid_rst", {bus.o_tgl, bus.o_busy, bus.o_pend, bus.o_ovf, bus.o_tmo}, 32'd0);
        rst = 1'b0;
        ack_man = 1'b0;
        f0 = flips;
        repeat (20) step();
        check("mid_no_flip", flips - f0, 0);
        check("mid_idle", {31'd0, bus.o_busy}, 32'd0);

`ifdef CDC_PULSE_TX_TIMEOUT_EN
        // Stuck ack: watchdog fires on the 15th cycle spent in WAIT.
        do_reset();
        ack_loop = 1'b0;
        ack_man = 1'b0;
        bus.i_pulse = 1'b1;
        repeat (4) step();
        bus.i_pulse = 1'b0;
        repeat (11) step();
        check("tmo_before", {bus.o_tmo, bus.o_pend}, {1'b0, 4'd3});
        step();
        check("tmo_fire", {bus.o_tmo, bus.o_busy, bus.o_pend, bus.o_tgl}, {1'b1, 1'b0, 4'd0, 1'b0});
`endif

        // Random bursts below saturation, checked against event conservation.
        do_reset();
        ack_loop = 1'b1;
        base = far_cnt;
        for (int b = 0; b < 30; b++) begin
            int len;
            int k;
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                bus.i_pulse = ($urandom_range(0, 1) == 1);
                step();
                check("rnd_conserve", flips + int'(bus.o_pend), n_in);
            end
            bus.i_pulse = 1'b0;
            k = 0;
            while (bus.o_busy && k < 200) begin
                step();
                check("rnd_conserve", flips + int'(bus.o_pend), n_in);
                k++;
            end
            check("rnd_drain", {31'd0, bus.o_busy}, 32'd0);
            repeat ($urandom_range(0, 5)) step();
        end
        repeat (10) step();
        check("rnd_far", far_cnt - base, n_in);
        check("rnd_ovf", {31'd0, bus.o_ovf}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
